// File: rtl/seq_divmod_if.sv
// -----------------------------------------------------------------------------
// seq_divmod_if
// Handshake and data bundle between a requester and the sequential divider.
//
// Signals (direction as seen from the divider, i.e. the slave modport):
//   start     in   request to begin an operation (sampled only when not busy)
//   dividend  in   WIDTH-bit unsigned dividend, captured on the accepted start
//   divisor   in   WIDTH-bit unsigned divisor, captured on the accepted start
//   busy      out  high while an accepted operation is in progress
//   done      out  one-cycle completion pulse; results valid from this cycle on
//   quotient  out  floor(dividend / divisor)
//   remainder out  dividend mod divisor
//   divZero   out  2'b01 when the last operation had divisor 0, else 2'b00
// -----------------------------------------------------------------------------
interface seq_divmod_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [1:0]       divZero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, divZero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, divZero
    );
endinterface

// File: rtl/seq_divmod.sv
// -----------------------------------------------------------------------------
// seq_divmod
// Unsigned restoring shift-subtract divider producing one quotient bit per
// clock. An accepted start with a nonzero divisor completes WIDTH cycles later;
// a zero divisor completes on the start edge itself with quotient all-ones,
// remainder = dividend and divZero = 2'b01. Results hold until the next
// completion or reset.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset (priority over start)
//   bus  slave modport of seq_divmod_if (start/operands in, status/results out)
// -----------------------------------------------------------------------------
module seq_divmod #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    seq_divmod_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] dsr_q, dsr_d;    // latched divisor
    logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder, always < divisor
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;    // quotient output register
    logic [WIDTH-1:0] rmo_q, rmo_d;    // remainder output register
    logic [1:0]       dz_q, dz_d;
    logic             done_q, done_d;

    // Working remainder is WIDTH+1 bits: the shifted partial remainder can
    // reach 2*divisor-1, which overflows WIDTH bits for large divisors.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;

    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign fits      = (rem_shift >= {1'b0, dsr_q});
    // The difference is below divisor, so the low WIDTH bits are exact.
    assign rem_sub   = rem_shift[WIDTH-1:0] - dsr_q;

    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement leaves one unassigned and no latch appears.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quo_d  = '1;
                        rmo_d  = bus.dividend;
                        dz_d   = 2'b01;
                        done_d = 1'b1;
                    end else begin
                        dvd_d   = bus.dividend;
                        dsr_d   = bus.divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], fits};
                rem_d = fits ? rem_sub : rem_shift[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Final step: publish the values this cycle produces.
                    quo_d   = dvd_d;
                    rmo_d   = rem_d;
                    dz_d    = 2'b00;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmo_q   <= '0;
            dz_q    <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q == CALC);
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmo_q;
    assign bus.divZero   = dz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// -----------------------------------------------------------------------------
// tb_seq_divmod
// Self-checking bench for seq_divmod at WIDTH=16 and WIDTH=8. A cycle-level
// model built from plain '/' and '%' predicts busy/done/results; a single
// negedge process compares both instances against it every cycle after the
// first reset. Directed operations add literal expectations for latency and
// results.
// -----------------------------------------------------------------------------
module tb_seq_divmod;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divmod_if #(.WIDTH(16)) b16 ();
    seq_divmod_if #(.WIDTH(8))  b8  ();

    seq_divmod #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    seq_divmod #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          left;   // cycles until a pending result is published
        logic        busy;
        logic        done;
        logic [31:0] q;
        logic [31:0] r;
        logic [1:0]  dz;
        logic [31:0] pq;
        logic [31:0] pr;
    } mdl_t;

    function automatic mdl_t step(input mdl_t m, input int w, input logic rs,
                                  input logic st, input logic [31:0] p, input logic [31:0] d);
        mdl_t n;
        logic [31:0] mask;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        n      = m;
        n.done = 1'b0;
        if (rs) begin
            n.left = 0; n.busy = 1'b0; n.q = '0; n.r = '0; n.dz = 2'b00;
            n.pq = '0; n.pr = '0;
        end else if (m.left > 0) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.done = 1'b1; n.busy = 1'b0; n.q = m.pq; n.r = m.pr; n.dz = 2'b00;
            end
        end else if (st === 1'b1) begin
            if (d == 0) begin
                n.done = 1'b1; n.q = mask; n.r = p; n.dz = 2'b01;
            end else begin
                n.pq = p / d; n.pr = p % d; n.left = w; n.busy = 1'b1;
            end
        end
        return n;
    endfunction

    mdl_t m16, m8;
    bit   armed = 1'b0;

    always @(negedge clk) begin
        if (armed) begin
            check("w16 busy",      b16.busy,      m16.busy);
            check("w16 done",      b16.done,      m16.done);
            check("w16 quotient",  b16.quotient,  m16.q);
            check("w16 remainder", b16.remainder, m16.r);
            check("w16 divZero",   b16.divZero,   m16.dz);
            check("w8 busy",       b8.busy,       m8.busy);
            check("w8 done",       b8.done,       m8.done);
            check("w8 quotient",   b8.quotient,   m8.q);
            check("w8 remainder",  b8.remainder,  m8.r);
            check("w8 divZero",    b8.divZero,    m8.dz);
        end
        m16 = step(m16, 16, rst, b16.start, {16'b0, b16.dividend}, {16'b0, b16.divisor});
        m8  = step(m8,  8,  rst, b8.start,  {24'b0, b8.dividend},  {24'b0, b8.divisor});
        if (rst === 1'b1) armed = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit w8, input logic st, input logic [15:0] p, input logic [15:0] d);
        if (w8) begin
            b8.start = st; b8.dividend = p[7:0]; b8.divisor = d[7:0];
        end else begin
            b16.start = st; b16.dividend = p; b16.divisor = d;
        end
    endtask

    // Called just after the accept edge E(already); returns the edge index of
    // done and the number of busy samples seen before it.
    task automatic wait_done(input bit w8, input int already, output int lat, output int bc);
        lat = -1;
        bc  = 0;
        for (int i = already; i <= already + 40; i++) begin
            if (i > already) begin
                @(posedge clk);
                #1;
            end
            if ((w8 ? b8.done : b16.done) === 1'b1) begin
                lat = i;
                break;
            end
            if ((w8 ? b8.busy : b16.busy) === 1'b1) bc++;
        end
        if (lat < 0) check("done timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input bit w8, input logic [15:0] p, input logic [15:0] d,
                          output int lat, output int bc);
        @(posedge clk); #1 drive(w8, 1'b1, p, d);
        @(posedge clk); #1 drive(w8, 1'b0, p, d);
        wait_done(w8, 0, lat, bc);
    endtask

    task automatic expect_op(input string name, input bit w8,
                             input logic [15:0] p, input logic [15:0] d, input int exp_lat,
                             input logic [15:0] eq, input logic [15:0] er, input logic [1:0] edz);
        int lat, bc;
        run_op(w8, p, d, lat, bc);
        check({name, " latency"},   lat, exp_lat);
        check({name, " busy cyc"},  bc,  exp_lat);
        check({name, " quotient"},  w8 ? {24'b0, b8.quotient}  : {16'b0, b16.quotient},  {16'b0, eq});
        check({name, " remainder"}, w8 ? {24'b0, b8.remainder} : {16'b0, b16.remainder}, {16'b0, er});
        check({name, " divZero"},   w8 ? b8.divZero : b16.divZero, edz);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, bc, dn;
        logic [15:0] p, d;

        rst = 1'b1;
        drive(1'b0, 1'b1, 16'd100, 16'd7);
        drive(1'b1, 1'b1, 16'd100, 16'd7);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",      b16.busy,      0);
        check("reset done",      b16.done,      0);
        check("reset quotient",  b16.quotient,  0);
        check("reset remainder", b16.remainder, 0);
        check("reset divZero",   b16.divZero,   0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0);
        @(posedge clk); #1;
        check("no op after reset", b16.busy, 0);

        expect_op("100/7",     1'b0, 16'd100,   16'd7,    16, 16'd14,   16'd2, 2'b00);
        expect_op("ffff/1",    1'b0, 16'hFFFF,  16'd1,    16, 16'hFFFF, 16'd0, 2'b00);
        expect_op("3/10",      1'b0, 16'd3,     16'd10,   16, 16'd0,    16'd3, 2'b00);
        expect_op("ffff/ffff", 1'b0, 16'hFFFF,  16'hFFFF, 16, 16'd1,    16'd0, 2'b00);
        expect_op("5/0",       1'b0, 16'd5,     16'd0,    0,  16'hFFFF, 16'd5, 2'b01);
        expect_op("9/4",       1'b0, 16'd9,     16'd4,    16, 16'd2,    16'd1, 2'b00);

        // Start ignored while busy; operands changed mid-operation.
        @(posedge clk); #1 drive(1'b0, 1'b1, 16'd50, 16'd6);
        @(posedge clk); #1 drive(1'b0, 1'b0, 16'd50, 16'd6);
        repeat (4) @(posedge clk);
        #1 drive(1'b0, 1'b1, 16'd1, 16'd1);
        @(posedge clk); #1 drive(1'b0, 1'b0, 16'd1, 16'd1);
        wait_done(1'b0, 5, lat, bc);
        check("50/6 latency",   lat, 16);
        check("50/6 quotient",  b16.quotient,  8);
        check("50/6 remainder", b16.remainder, 2);

        // Back-to-back: start in the done cycle.
        drive(1'b0, 1'b1, 16'd20, 16'd3);
        @(posedge clk); #1 drive(1'b0, 1'b0, 16'd20, 16'd3);
        wait_done(1'b0, 0, lat, bc);
        check("b2b latency",   lat, 16);
        check("b2b quotient",  b16.quotient,  6);
        check("b2b remainder", b16.remainder, 2);

        // Reset mid-operation.
        @(posedge clk); #1 drive(1'b0, 1'b1, 16'd1000, 16'd9);
        @(posedge clk); #1 drive(1'b0, 1'b0, 16'd1000, 16'd9);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort busy",      b16.busy,      0);
        check("abort quotient",  b16.quotient,  0);
        check("abort remainder", b16.remainder, 0);
        dn = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (b16.done === 1'b1) dn++;
        end
        check("abort no done", dn, 0);

        expect_op("w8 200/13", 1'b1, 16'd200, 16'd13, 8, 16'd15,  16'd5,  2'b00);
        expect_op("w8 255/1",  1'b1, 16'd255, 16'd1,  8, 16'd255, 16'd0,  2'b00);
        expect_op("w8 7/0",    1'b1, 16'd7,   16'd0,  0, 16'd255, 16'd7,  2'b01);

        // Random sweep; the per-cycle compare process checks the results.
        for (int n = 0; n < 30; n++) begin
            p = 16'($urandom);
            d = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(1, 15));
            run_op(1'b0, p, d, lat, bc);
            check("rand16 latency", lat, (d == 0) ? 0 : 16);
        end
        for (int n = 0; n < 30; n++) begin
            p = 16'($urandom_range(0, 255));
            d = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 255));
            run_op(1'b1, p, d, lat, bc);
            check("rand8 latency", lat, (d[7:0] == 0) ? 0 : 8);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
